prbs_checker: RTL

Receive-side companion to the team's 4-bit LFSR pattern generator. Consumes a serial bitstream one bit per valid beat, self-synchronises a local Fibonacci LFSR to it, declares lock after a run of correct predictions, then counts bit errors against the free-running local sequence. Sits at the end of a link under test or in a BIST loopback, opposite the generator.

---
 rtl/lfsr_pkg.sv | 20 ++
 rtl/prbs_checker.sv | 139 +++++++++++++
 2 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the pattern generator and the PRBS checker.
// Both ends take their feedback from lfsr_fb so they agree on one polynomial.
package lfsr_pkg;

    // Widest LFSR the shared feedback function supports.
    localparam int LFSR_MAX_W = 32;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lfsr_state_t;

    // XOR feedback of the register bits selected by taps. Callers zero-extend.
    function automatic logic lfsr_fb(input logic [LFSR_MAX_W-1:0] sreg,
                                     input logic [LFSR_MAX_W-1:0] taps);
        return ^(sreg & taps);
    endfunction

endpackage

// File: rtl/prbs_checker.sv
// Receive-side PRBS checker: self-synchronises a local Fibonacci LFSR to the
// incoming bitstream, locks after a run of correct predictions, then counts
// bit errors against the free-running local sequence.
module prbs_checker
    import lfsr_pkg::*;
#(
    parameter int             WIDTH       = 4,
    parameter logic [WIDTH-1:0] TAPS      = 4'b1100,
    parameter int             LOCK_COUNT  = 8,
    parameter int             UNLOCK_ERRS = 3,
    parameter int             CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_err,
    output logic             lock,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam int HW = $clog2(WIDTH + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(UNLOCK_ERRS + 1);

    // Counter values on the beat that completes each phase.
    localparam logic [HW-1:0] HUNT_LAST  = HW'(WIDTH - 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [BW-1:0] BAD_LAST   = BW'(UNLOCK_ERRS - 1);

    lfsr_state_t      state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [HW-1:0]    hunt_cnt, hunt_nxt;
    logic [MW-1:0]    match_cnt, match_nxt;
    logic [BW-1:0]    bad_run, bad_nxt;
    logic             pb;
    logic             err_hit;

    assign pb = lfsr_fb(LFSR_MAX_W'(sreg), LFSR_MAX_W'(TAPS));

    // State, LFSR and run counters; everything holds on beats without in_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HUNT;
            sreg      <= '0;
            hunt_cnt  <= '0;
            match_cnt <= '0;
            bad_run   <= '0;
            lock      <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            sreg      <= sreg_nxt;
            hunt_cnt  <= hunt_nxt;
            match_cnt <= match_nxt;
            bad_run   <= bad_nxt;
            lock      <= (state_nxt == LOCKED);
            err_pulse <= err_hit;
        end
    end

    // Saturating error counter; a clear on an erroring beat leaves that error counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clr_err) begin
            err_count <= err_hit ? CNT_W'(1) : '0;
        end else if (err_hit && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

    // Next-state: seed from the stream in HUNT/VERIFY, free-run once LOCKED.
    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        hunt_nxt  = hunt_cnt;
        match_nxt = match_cnt;
        bad_nxt   = bad_run;
        err_hit   = 1'b0;
        if (in_valid) begin
            unique case (state)
                HUNT: begin
                    sreg_nxt = {sreg[WIDTH-2:0], in_bit};
                    if (hunt_cnt == HUNT_LAST) begin
                        hunt_nxt = '0;
                        // All-zero is the lock-up state and never a valid seed.
                        if (sreg_nxt != '0) begin
                            state_nxt = VERIFY;
                            match_nxt = '0;
                        end
                    end else begin
                        hunt_nxt = hunt_cnt + 1'b1;
                    end
                end
                VERIFY: begin
                    sreg_nxt = {sreg[WIDTH-2:0], in_bit};
                    if (in_bit == pb) begin
                        if (match_cnt == MATCH_LAST) begin
                            state_nxt = LOCKED;
                            match_nxt = '0;
                            bad_nxt   = '0;
                        end else begin
                            match_nxt = match_cnt + 1'b1;
                        end
                    end else begin
                        // The mismatching bit already sits in sreg as the first seed bit.
                        state_nxt = HUNT;
                        hunt_nxt  = HW'(1);
                        match_nxt = '0;
                    end
                end
                LOCKED: begin
                    sreg_nxt = {sreg[WIDTH-2:0], pb};
                    if (in_bit != pb) begin
                        err_hit = 1'b1;
                        if (bad_run == BAD_LAST) begin
                            state_nxt = HUNT;
                            hunt_nxt  = '0;
                            bad_nxt   = '0;
                        end else begin
                            bad_nxt = bad_run + 1'b1;
                        end
                    end else begin
                        bad_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    hunt_nxt  = '0;
                    match_nxt = '0;
                    bad_nxt   = '0;
                end
            endcase
        end
    end

endmodule
